mem_arbiter: RTL

Sequential arbiter that shares the single-port, fixed-latency external memory between instruction fetch (IF) and the MEM stage (LD/ST driven by the control unit's mem_read/mem_write). It serializes the two requesters (MEM first), runs each access as a multi-cycle transaction, and raises a global freeze until every outstanding request of the current pipeline step is served. It sits between the IF/MEM stages and the memory pins, with freeze fanning out to all pipeline registers and the PC.

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one fixed-latency memory port between IF and MEM,
//               MEM first, freezing the pipeline until the step is served.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              freeze,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    output logic              ext_we,
    output logic              ext_oe,
    input  logic [DATA_W-1:0] ext_rdata
);

    localparam int c_CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_grant_mem;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_mem_done;
    logic                r_if_done;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_if_ready;
    logic                r_mem_ready;
    logic [ADDR_W-1:0]   r_ext_addr;
    logic [DATA_W-1:0]   r_ext_wdata;
    logic                r_ext_we;
    logic                r_ext_oe;
    logic                w_eff_mem;
    logic                w_eff_if;
    logic                w_cnt_last;
    logic                w_freeze;

    assign w_eff_mem  = (mem_read | mem_write) & ~r_mem_done;
    assign w_eff_if   = if_req & ~r_if_done;
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_freeze    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_eff_mem || w_eff_if) begin
                    w_state_nxt = ST_BUSY;
                    w_freeze    = 1'b1;
                end
            end
            ST_BUSY: begin
                w_freeze = 1'b1;
                if (w_cnt_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                // The granted side is served; only the other side keeps us stalled.
                w_freeze    = r_grant_mem ? w_eff_if : w_eff_mem;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            w_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_mem <= 1'b1;
            r_cnt       <= '0;
            r_mem_done  <= 1'b0;
            r_if_done   <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_ext_we    <= 1'b0;
            r_ext_oe    <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_eff_mem) begin
                        r_grant_mem <= 1'b1;
                        r_ext_addr  <= mem_addr;
                        r_cnt       <= '0;
                        // A simultaneous read+write request is executed as a store.
                        if (mem_write) begin
                            r_ext_wdata <= mem_wdata;
                            r_ext_we    <= 1'b1;
                            r_ext_oe    <= 1'b0;
                        end else begin
                            r_ext_we    <= 1'b0;
                            r_ext_oe    <= 1'b1;
                        end
                    end else if (w_eff_if) begin
                        r_grant_mem <= 1'b0;
                        r_ext_addr  <= if_addr;
                        r_cnt       <= '0;
                        r_ext_we    <= 1'b0;
                        r_ext_oe    <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_cnt_last) begin
                        if (r_ext_oe) begin
                            if (r_grant_mem) begin
                                r_mem_rdata <= ext_rdata;
                            end else begin
                                r_if_rdata  <= ext_rdata;
                            end
                        end
                        r_ext_we    <= 1'b0;
                        r_ext_oe    <= 1'b0;
                        r_mem_ready <= r_grant_mem;
                        r_if_ready  <= ~r_grant_mem;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            // An unfrozen cycle advances the pipeline, so any request seen next is new.
            if (!w_freeze) begin
                r_mem_done <= 1'b0;
                r_if_done  <= 1'b0;
            end else if (r_state == ST_DONE) begin
                if (r_grant_mem) begin
                    r_mem_done <= 1'b1;
                end else begin
                    r_if_done  <= 1'b1;
                end
            end
        end
    end

    assign freeze    = w_freeze;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign mem_rdata = r_mem_rdata;
    assign mem_ready = r_mem_ready;
    assign ext_addr  = r_ext_addr;
    assign ext_wdata = r_ext_wdata;
    assign ext_we    = r_ext_we;
    assign ext_oe    = r_ext_oe;

endmodule
`default_nettype wire
